// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor: edge-count FSM states and the
// saturation helper used by the period and high-time counters.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    MEAS_IDLE  = 2'd0,
    MEAS_COUNT = 2'd1,
    MEAS_DONE  = 2'd2
  } meas_state_e;

  // Widest counter the saturation helper can judge.
  localparam int unsigned SAT_MAX_W = 64;
  // All-ones value; a counter of width W saturates at the low W bits of this.
  localparam logic [SAT_MAX_W-1:0] SAT_ONES = {SAT_MAX_W{1'b1}};

  // True when the low 'width' bits of value are all ones (counter overflow).
  function automatic logic is_saturated(input logic [SAT_MAX_W-1:0] value,
                                        input int unsigned width);
    return value == (SAT_ONES >> (SAT_MAX_W - width));
  endfunction

endpackage

// File: rtl/clock_monitor_sync.sv
// Synchronizer chain for the observed clock. SYNC_STAGES flops, all cleared
// by the synchronous reset so the monitor restarts from a known low level.
module clock_monitor_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the chain
  always_ff @(posedge clock) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: samples mon_clk in the clock domain, measures its period and
// high time, counts a requested number of rising edges, and (when the macro
// CLOCK_MONITOR_STOP_DETECT_EN is defined) flags a stopped clock and aborts
// an in-flight count. Without the macro, stopped and meas_err are tied low.
//
// Handshake: meas_start is a single-cycle request honoured only while idle;
// meas_busy is high for the whole count, meas_done pulses for one cycle at
// completion and meas_err is meaningful in that same cycle.
module clock_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 16,
  parameter int EDGE_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mon_clk,
  input  logic              meas_start,
  input  logic [EDGE_W-1:0] meas_num_edges,
  output logic              meas_busy,
  output logic              meas_done,
  output logic              meas_err,
  output logic [EDGE_W-1:0] edge_count,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              period_valid,
  output logic              stopped
);

  import clock_monitor_pkg::*;

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("clock_monitor: SYNC_STAGES must be 2 or more");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("clock_monitor: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

  logic              sync_lvl;
  logic              hist;
  logic              rise;
  logic              fall;
  logic              stop_event;
  logic              seen_rise;
  logic              per_sat;
  logic              hi_sat;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [EDGE_W-1:0] target;
  meas_state_e       state;
  meas_state_e       next_state;

  clock_monitor_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (mon_clk),
    .q    (sync_lvl)
  );

  assign rise    = sync_lvl & ~hist;
  assign fall    = ~sync_lvl & hist;
  assign per_sat = is_saturated(64'(per_cnt), CNT_W);
  assign hi_sat  = is_saturated(64'(hi_cnt), CNT_W);

  // Period / high-time measurement; the first rise after (re)start only arms it
  always_ff @(posedge clock) begin
    if (reset) begin
      hist         <= 1'b0;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      seen_rise    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
    end else begin
      hist <= sync_lvl;
      if (rise) begin
        hi_cnt <= '0;
        if (seen_rise) begin
          period       <= per_cnt;
          per_cnt      <= CNT_ONE;
          period_valid <= 1'b1;
        end else begin
          per_cnt   <= '0;
          seen_rise <= 1'b1;
        end
      end else begin
        if (!per_sat) per_cnt <= per_cnt + CNT_ONE;
        if (sync_lvl && !hi_sat) hi_cnt <= hi_cnt + CNT_ONE;
        if (fall && seen_rise) high_time <= hi_cnt;
        // A stopped clock invalidates the measurement and re-arms it
        if (stop_event) begin
          period_valid <= 1'b0;
          seen_rise    <= 1'b0;
        end
      end
    end
  end

`ifdef CLOCK_MONITOR_STOP_DETECT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Cycles since the last rise, holding at the limit so the stop fires once
  always_ff @(posedge clock) begin
    if (reset)                  to_cnt <= '0;
    else if (rise)              to_cnt <= '0;
    else if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + TO_W'(1);
  end

  assign stop_event = ~rise & (to_cnt == TO_LAST);

  // Stopped flag and abort status for the edge count
  always_ff @(posedge clock) begin
    if (reset) begin
      stopped  <= 1'b0;
      meas_err <= 1'b0;
    end else begin
      if (rise)            stopped <= 1'b0;
      else if (stop_event) stopped <= 1'b1;
      if (state == MEAS_COUNT && next_state == MEAS_DONE) meas_err <= stop_event;
      else if (state == MEAS_IDLE && meas_start)          meas_err <= 1'b0;
    end
  end
`else
  assign stop_event = 1'b0;
  assign stopped    = 1'b0;
  assign meas_err   = 1'b0;
`endif

  // Edge counter and latched target for the current request
  always_ff @(posedge clock) begin
    if (reset) begin
      edge_count <= '0;
      target     <= '0;
    end else if (state == MEAS_IDLE && meas_start) begin
      edge_count <= '0;
      target     <= meas_num_edges;
    end else if (state == MEAS_COUNT && rise) begin
      edge_count <= edge_count + EDGE_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= MEAS_IDLE;
    else       state <= next_state;
  end

  // FSM next state: a zero request completes straight away
  always_comb begin
    next_state = state;
    case (state)
      MEAS_IDLE: begin
        if (meas_start) begin
          next_state = (meas_num_edges == '0) ? MEAS_DONE : MEAS_COUNT;
        end
      end
      MEAS_COUNT: begin
        if (rise && ((edge_count + EDGE_ONE) == target)) next_state = MEAS_DONE;
        else if (stop_event)                            next_state = MEAS_DONE;
      end
      MEAS_DONE: next_state = MEAS_IDLE;
      default:   next_state = MEAS_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    meas_busy = (state == MEAS_COUNT);
    meas_done = (state == MEAS_DONE);
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor. A cycle-level behavioural model of
// the monitor's rules is compared against the DUT every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_clock_monitor;

  localparam int SYNC_STAGES    = 2;
  localparam int CNT_W          = 8;
  localparam int EDGE_W         = 16;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;
`ifdef CLOCK_MONITOR_STOP_DETECT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              mon_clk;
  logic              meas_start;
  logic [EDGE_W-1:0] meas_num_edges;
  logic              meas_busy;
  logic              meas_done;
  logic              meas_err;
  logic [EDGE_W-1:0] edge_count;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  high_time;
  logic              period_valid;
  logic              stopped;

  int checks = 0;
  int errors = 0;

  clock_monitor #(
    .SYNC_STAGES   (SYNC_STAGES),
    .CNT_W         (CNT_W),
    .EDGE_W        (EDGE_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mon_clk       (mon_clk),
    .meas_start    (meas_start),
    .meas_num_edges(meas_num_edges),
    .meas_busy     (meas_busy),
    .meas_done     (meas_done),
    .meas_err      (meas_err),
    .edge_count    (edge_count),
    .period        (period),
    .high_time     (high_time),
    .period_valid  (period_valid),
    .stopped       (stopped)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- observed clock generator ----------------
  int mon_half = 5;
  bit mon_gate = 1'b1;
  int ph;

  initial begin
    mon_clk = 1'b0;
    ph = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mon_gate) begin
        mon_clk = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= mon_half) begin
          mon_clk = ~mon_clk;
          ph = 0;
        end
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The DUT sees mon_clk through SYNC_STAGES flops; smp holds the sampled
  // history so the model can tell when a mon_clk edge becomes visible.
  logic smp [0:SYNC_STAGES];
  int   cyc = 0;
  int   last_rise = 0;
  int   anchor = 0;
  bit   armed, first_pub, model_live;
  logic [31:0] per_e, ht_e, cnt_e, tgt_e;
  bit   pv_e, stop_e, busy_e, done_e, err_e;
  logic [EDGE_W-1:0] exp_q[$];

  function automatic logic [31:0] sat(input int v);
    return (v > CNT_MAX) ? 32'(CNT_MAX) : 32'(v);
  endfunction

  always @(posedge clock) begin
    bit lvl, prv, rise, fall, stop_ev;
    if (reset) begin
      armed = 0; first_pub = 0; per_e = 0; ht_e = 0; pv_e = 0; stop_e = 0;
      busy_e = 0; done_e = 0; err_e = 0; cnt_e = 0; tgt_e = 0;
      anchor = cyc;
      for (int i = 0; i <= SYNC_STAGES; i++) smp[i] = 1'b0;
    end else begin
      lvl = smp[SYNC_STAGES-1];
      prv = smp[SYNC_STAGES];
      rise = lvl && !prv;
      fall = !lvl && prv;
      stop_ev = STOP_EN && !rise && (cyc - anchor == TIMEOUT_CYCLES);
      // period = cycles between visible rises; the interval right after
      // arming is one short because the first rise zeroes the counter
      if (rise) begin
        if (armed) begin
          per_e = sat(cyc - last_rise - (first_pub ? 1 : 0));
          pv_e = 1;
          first_pub = 0;
        end else begin
          armed = 1;
          first_pub = 1;
        end
        last_rise = cyc;
        anchor = cyc;
        stop_e = 0;
      end else if (fall && armed) begin
        ht_e = sat(cyc - last_rise - 1);
      end
      if (stop_ev) begin
        stop_e = 1;
        pv_e = 0;
        armed = 0;
      end
      // edge-count request
      if (done_e) begin
        done_e = 0;
      end else if (busy_e) begin
        if (rise) begin
          cnt_e++;
          if (cnt_e == tgt_e) begin busy_e = 0; done_e = 1; err_e = 0; end
        end else if (stop_ev) begin
          busy_e = 0; done_e = 1; err_e = 1;
        end
      end else if (meas_start) begin
        cnt_e = 0;
        if (meas_num_edges == '0) begin done_e = 1; err_e = 0; end
        else begin busy_e = 1; tgt_e = 32'(meas_num_edges); end
      end
      if (done_e) exp_q.push_back(cnt_e[EDGE_W-1:0]);
    end
    for (int i = SYNC_STAGES; i > 0; i--) smp[i] = smp[i-1];
    smp[0] = reset ? 1'b0 : mon_clk;
    cyc++;
    model_live = 1;
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clock) begin
    if (model_live) begin
      check("period", 32'(period), per_e);
      check("high_time", 32'(high_time), ht_e);
      check("period_valid", 32'(period_valid), 32'(pv_e));
      check("stopped", 32'(stopped), 32'(stop_e));
      check("meas_busy", 32'(meas_busy), 32'(busy_e));
      check("meas_done", 32'(meas_done), 32'(done_e));
      check("edge_count", 32'(edge_count), cnt_e);
      if (done_e) check("meas_err", 32'(meas_err), 32'(err_e));
      if (meas_done) begin
        check("done_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("done_count", 32'(edge_count), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_meas(input int n);
    @(posedge clock); #1;
    meas_start = 1'b1;
    meas_num_edges = EDGE_W'(n);
    @(posedge clock); #1;
    meas_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output logic [31:0] cnt,
                           output logic err, output logic stp, output logic pv);
    got = 0; cnt = 0; err = 0; stp = 0; pv = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (meas_done) begin
        got = 1; cnt = 32'(edge_count); err = meas_err; stp = stopped; pv = period_valid;
      end
    end
  endtask

  task automatic wait_count(input int n, input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (edge_count >= EDGE_W'(n)) got = 1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit got;
    logic [31:0] cnt;
    logic err, stp, pv;
    int dones;

    reset = 1'b1;
    meas_start = 1'b0;
    meas_num_edges = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_period", 32'(period), 0);
    check("rst_high_time", 32'(high_time), 0);
    check("rst_period_valid", 32'(period_valid), 0);
    check("rst_busy", 32'(meas_busy), 0);
    check("rst_edge_count", 32'(edge_count), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mon_gate = 1'b0;

    // free-running half-period 5
    repeat (40) @(posedge clock);
    @(negedge clock);
    check_range("free_period", 32'(period), 9, 11);
    check_range("free_high_time", 32'(high_time), 4, 6);
    check("free_period_valid", 32'(period_valid), 1);

    // count 7 edges
    start_meas(7);
    wait_done(200, got, cnt, err, stp, pv);
    check("cnt7_done_seen", 32'(got), 1);
    check("cnt7_edge_count", cnt, 7);
    check("cnt7_err", 32'(err), 0);

    // zero-edge request completes immediately without busy
    start_meas(0);
    @(negedge clock);
    check("zero_done", 32'(meas_done), 1);
    check("zero_busy", 32'(meas_busy), 0);
    check("zero_edge_count", 32'(edge_count), 0);

    // a second start while busy is ignored
    start_meas(3);
    repeat (2) @(posedge clock);
    start_meas(50);
    wait_done(200, got, cnt, err, stp, pv);
    check("ignore_done_seen", 32'(got), 1);
    check("ignore_edge_count", cnt, 3);

    // reset during a count drops it
    start_meas(20);
    repeat (15) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rstcnt_busy", 32'(meas_busy), 0);
    check("rstcnt_done", 32'(meas_done), 0);
    check("rstcnt_edge_count", 32'(edge_count), 0);
    check("rstcnt_period", 32'(period), 0);
    check("rstcnt_high_time", 32'(high_time), 0);
    check("rstcnt_period_valid", 32'(period_valid), 0);
    check("rstcnt_stopped", 32'(stopped), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (meas_done) dones++;
    end
    check("rstcnt_no_done", 32'(dones), 0);
    start_meas(2);
    wait_done(100, got, cnt, err, stp, pv);
    check("after_rst_done_seen", 32'(got), 1);
    check("after_rst_edge_count", cnt, 2);

`ifdef CLOCK_MONITOR_STOP_DETECT_EN
    // gate the clock mid-count: the count aborts on the timeout
    start_meas(20);
    wait_count(5, 200, got);
    check("stop_reached_5", 32'(got), 1);
    @(posedge clock); #1;
    mon_gate = 1'b1;
    wait_done(300, got, cnt, err, stp, pv);
    check("stop_done_seen", 32'(got), 1);
    check("stop_err", 32'(err), 1);
    check("stop_stopped", 32'(stp), 1);
    check("stop_period_valid", 32'(pv), 0);
    @(posedge clock); #1;
    mon_gate = 1'b0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (!stopped) got = 1;
    end
    check("stop_cleared", 32'(got), 1);
    check("stop_first_rise_no_publish", 32'(period_valid), 0);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (period_valid) got = 1;
    end
    check("stop_republished", 32'(got), 1);
    check_range("stop_period", 32'(period), 9, 11);
`else
    // without stop detection a gated count simply waits
    start_meas(5);
    wait_count(2, 100, got);
    check("gate_reached_2", 32'(got), 1);
    @(posedge clock); #1;
    mon_gate = 1'b1;
    repeat (150) @(negedge clock);
    check("gate_still_busy", 32'(meas_busy), 1);
    check("gate_not_stopped", 32'(stopped), 0);
    @(posedge clock); #1;
    mon_gate = 1'b0;
    wait_done(200, got, cnt, err, stp, pv);
    check("gate_done_seen", 32'(got), 1);
    check("gate_edge_count", cnt, 5);
    check("gate_err", 32'(err), 0);

    // very slow clock: both measurements saturate at all-ones
    mon_half = 300;
    repeat (1900) @(posedge clock);
    @(negedge clock);
    check("sat_period", 32'(period), 32'hFF);
    check("sat_high_time", 32'(high_time), 32'hFF);
    check("sat_period_valid", 32'(period_valid), 1);
`endif

    repeat (3) @(negedge clock);
    check("done_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
